// File: rtl/uart_hex_rx.sv
// UART receiver that assembles 8 ASCII hex digits plus a terminator into a 32-bit seed word.
// Optional even-parity bit between data and stop is enabled by defining RX_PARITY_EN.
module uart_hex_rx #(
   parameter int CLK_HZ = 24000000,
   parameter int BAUD   = 9600,
   parameter int OSR    = 16
) (
   input  logic        uart_clk,
   input  logic        reset1,
   input  logic        rxd,
   output logic [7:0]  rx_byte,
   output logic        rx_byte_valid,
   output logic [31:0] seed_word,
   output logic        seed_valid,
   input  logic        seed_ack,
   output logic        frame_error,
   output logic        parse_error,
   output logic        overrun
);

   localparam int TICK_DIV = CLK_HZ / (BAUD * OSR);
   localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int OW = $clog2(OSR);

`ifdef RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

   state_t r_state, w_nextState;

   logic          r_rxMeta, r_rxSync, r_rxPrev, r_armed;
   logic [1:0]    r_fill;
   logic [TW-1:0] r_tickCnt;
   logic [OW-1:0] r_osCnt;
   logic [2:0]    r_bitCnt;
   logic [7:0]    r_shift, r_rxByte;
   logic          r_rxValid, r_frameErr;
   logic          w_tick, w_fall, w_osDone, w_sampleData, w_sampleStop, w_parOk;
`ifdef RX_PARITY_EN
   logic          r_parOk, w_samplePar;
`endif

   logic [3:0]    r_digCnt;
   logic [31:0]   r_acc, r_seedWord;
   logic          r_seedValid, r_overrun, r_parseError;
   logic          w_isHex, w_isTerm, w_complete;
   logic [3:0]    w_nibble;

   // Armed only once the synchronised line has really been seen high, so a low line at reset release cannot start a frame.
   always_ff @(posedge uart_clk or negedge reset1) begin
      if (!reset1) begin
         r_rxMeta <= 1'b1;
         r_rxSync <= 1'b1;
         r_rxPrev <= 1'b1;
         r_fill   <= 2'b00;
         r_armed  <= 1'b0;
      end else begin
         r_rxMeta <= rxd;
         r_rxSync <= r_rxMeta;
         r_rxPrev <= r_rxSync;
         r_fill   <= {r_fill[0], 1'b1};
         if (r_fill[1] && r_rxSync)
            r_armed <= 1'b1;
      end
   end

   assign w_fall = r_armed & r_rxPrev & ~r_rxSync;
   assign w_tick = (r_tickCnt == TW'(TICK_DIV - 1));

   always_ff @(posedge uart_clk or negedge reset1) begin
      if (!reset1)
         r_tickCnt <= '0;
      else if (w_tick)
         r_tickCnt <= '0;
      else
         r_tickCnt <= r_tickCnt + 1'b1;
   end

   always_ff @(posedge uart_clk or negedge reset1) begin
      if (!reset1)
         r_state <= S_IDLE;
      else
         r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      case (r_state)
         S_IDLE:   if (w_fall) w_nextState = S_START;
         S_START:  if (w_osDone) w_nextState = r_rxSync ? S_IDLE : S_DATA;
`ifdef RX_PARITY_EN
         S_DATA:   if (w_osDone && r_bitCnt == 3'd7) w_nextState = S_PARITY;
         S_PARITY: if (w_osDone) w_nextState = S_STOP;
`else
         S_DATA:   if (w_osDone && r_bitCnt == 3'd7) w_nextState = S_STOP;
`endif
         S_STOP:   if (w_osDone) w_nextState = S_IDLE;
         default:  w_nextState = S_IDLE;
      endcase
   end

   // START samples half a bit in; every later state samples one full bit after the previous sample.
   always_comb begin
      w_osDone = 1'b0;
      if (w_tick) begin
         case (r_state)
            S_IDLE:  w_osDone = 1'b0;
            S_START: w_osDone = (r_osCnt == OW'(OSR / 2 - 1));
            default: w_osDone = (r_osCnt == OW'(OSR - 1));
         endcase
      end
      w_sampleData = w_osDone && (r_state == S_DATA);
      w_sampleStop = w_osDone && (r_state == S_STOP);
`ifdef RX_PARITY_EN
      w_samplePar  = w_osDone && (r_state == S_PARITY);
`endif
   end

   always_ff @(posedge uart_clk or negedge reset1) begin
      if (!reset1) begin
         r_osCnt  <= '0;
         r_bitCnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_osCnt  <= '0;
         r_bitCnt <= '0;
      end else begin
         if (w_tick)
            r_osCnt <= w_osDone ? '0 : r_osCnt + 1'b1;
         if (w_sampleData)
            r_bitCnt <= r_bitCnt + 1'b1;
      end
   end

`ifdef RX_PARITY_EN
   assign w_parOk = r_parOk;
`else
   assign w_parOk = 1'b1;
`endif

   always_ff @(posedge uart_clk or negedge reset1) begin
      if (!reset1) begin
         r_shift    <= '0;
         r_rxByte   <= '0;
         r_rxValid  <= 1'b0;
         r_frameErr <= 1'b0;
`ifdef RX_PARITY_EN
         r_parOk    <= 1'b1;
`endif
      end else begin
         r_rxValid  <= 1'b0;
         r_frameErr <= 1'b0;
         if (w_sampleData)
            r_shift <= {r_rxSync, r_shift[7:1]};
`ifdef RX_PARITY_EN
         if (r_state == S_IDLE)
            r_parOk <= 1'b1;
         if (w_samplePar) begin
            r_parOk <= ~(^{r_shift, r_rxSync});
            if (^{r_shift, r_rxSync})
               r_frameErr <= 1'b1;
         end
`endif
         if (w_sampleStop) begin
            if (!r_rxSync)
               r_frameErr <= 1'b1;
            else if (w_parOk) begin
               r_rxByte  <= r_shift;
               r_rxValid <= 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_isHex  = 1'b1;
      w_nibble = 4'h0;
      if (r_rxByte >= 8'h30 && r_rxByte <= 8'h39)
         w_nibble = r_rxByte[3:0];
      else if ((r_rxByte >= 8'h41 && r_rxByte <= 8'h46) || (r_rxByte >= 8'h61 && r_rxByte <= 8'h66))
         w_nibble = r_rxByte[3:0] + 4'd9;
      else
         w_isHex = 1'b0;
      w_isTerm   = (r_rxByte == 8'h20) || (r_rxByte == 8'h0D) || (r_rxByte == 8'h0A);
      w_complete = r_rxValid && w_isTerm && (r_digCnt == 4'd8);
   end

   // An acknowledge in the same cycle as a completion frees the slot, so the new word loads without overrun.
   always_ff @(posedge uart_clk or negedge reset1) begin
      if (!reset1) begin
         r_digCnt     <= '0;
         r_acc        <= '0;
         r_seedWord   <= '0;
         r_seedValid  <= 1'b0;
         r_overrun    <= 1'b0;
         r_parseError <= 1'b0;
      end else begin
         r_parseError <= 1'b0;
         if (r_frameErr)
            r_digCnt <= '0;
         else if (r_rxValid) begin
            if (w_isHex) begin
               if (r_digCnt < 4'd8) begin
                  r_acc    <= {r_acc[27:0], w_nibble};
                  r_digCnt <= r_digCnt + 1'b1;
               end else begin
                  r_parseError <= 1'b1;
                  r_digCnt     <= '0;
               end
            end else if (w_isTerm) begin
               if (r_digCnt != 4'd0 && r_digCnt != 4'd8)
                  r_parseError <= 1'b1;
               r_digCnt <= '0;
            end else begin
               r_parseError <= 1'b1;
               r_digCnt     <= '0;
            end
         end
         if (w_complete) begin
            if (!r_seedValid || seed_ack) begin
               r_seedWord  <= r_acc;
               r_seedValid <= 1'b1;
            end else
               r_overrun <= 1'b1;
         end else if (seed_ack)
            r_seedValid <= 1'b0;
      end
   end

   assign rx_byte       = r_rxByte;
   assign rx_byte_valid = r_rxValid;
   assign frame_error   = r_frameErr;
   assign seed_word     = r_seedWord;
   assign seed_valid    = r_seedValid;
   assign parse_error   = r_parseError;
   assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_hex_rx.sv
// Self-checking bench for uart_hex_rx: directed lines plus randomized hex lines against a byte-level model.
// A fast baud setting keeps each bit at 32 clocks; honours RX_PARITY_EN like the design.
module tb_uart_hex_rx;

   localparam int CLK_HZ = 307200;
   localparam int BAUD   = 9600;
   localparam int OSR    = 16;
   localparam int BIT    = (CLK_HZ / (BAUD * OSR)) * OSR;
`ifdef RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif

   logic        uart_clk = 1'b0;
   logic        reset1   = 1'b0;
   logic        rxd      = 1'b1;
   logic        seed_ack = 1'b0;
   logic [7:0]  rx_byte;
   logic        rx_byte_valid;
   logic [31:0] seed_word;
   logic        seed_valid;
   logic        frame_error;
   logic        parse_error;
   logic        overrun;

   int vectors     = 0;
   int miscompares = 0;
   int nValid = 0, nFrame = 0, nParse = 0;

   int          mDigits[$];
   logic [31:0] mSeedWord  = '0;
   bit          mSeedValid = 1'b0;
   bit          mOverrun   = 1'b0;
   logic [7:0]  mRxByte    = '0;
   int          eValid = 0, eFrame = 0, eParse = 0;

   uart_hex_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD), .OSR(OSR)) dut (
      .uart_clk      (uart_clk),
      .reset1        (reset1),
      .rxd           (rxd),
      .rx_byte       (rx_byte),
      .rx_byte_valid (rx_byte_valid),
      .seed_word     (seed_word),
      .seed_valid    (seed_valid),
      .seed_ack      (seed_ack),
      .frame_error   (frame_error),
      .parse_error   (parse_error),
      .overrun       (overrun)
   );

   always #5 uart_clk = ~uart_clk;

   // Counting high cycles also catches pulses that stretch beyond one clock.
   always @(posedge uart_clk) begin
      if (rx_byte_valid) nValid++;
      if (frame_error)   nFrame++;
      if (parse_error)   nParse++;
   end

   function automatic int hexVal(input logic [7:0] c);
      if (c >= "0" && c <= "9") return int'(c) - 48;
      if (c >= "a" && c <= "f") return int'(c) - 87;
      if (c >= "A" && c <= "F") return int'(c) - 55;
      return -1;
   endfunction

   function automatic void modelByte(input logic [7:0] c);
      int v;
      logic [31:0] w;
      v = hexVal(c);
      eValid++;
      mRxByte = c;
      if (v >= 0) begin
         if (mDigits.size() < 8) mDigits.push_back(v);
         else begin eParse++; mDigits.delete(); end
      end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
         if (mDigits.size() == 8) begin
            w = 0;
            foreach (mDigits[i]) w = w * 16 + 32'(mDigits[i]);
            if (mSeedValid) mOverrun = 1'b1;
            else begin mSeedWord = w; mSeedValid = 1'b1; end
         end else if (mDigits.size() != 0)
            eParse++;
         mDigits.delete();
      end else begin
         eParse++;
         mDigits.delete();
      end
   endfunction

   function automatic void modelFrameErr();
      eFrame++;
      mDigits.delete();
   endfunction

   function automatic void modelReset();
      mDigits.delete();
      mSeedWord  = '0;
      mSeedValid = 1'b0;
      mOverrun   = 1'b0;
      mRxByte    = '0;
   endfunction

   function automatic logic [10:0] frameBits(input logic [7:0] c, input logic stopBit);
`ifdef RX_PARITY_EN
      return {stopBit, ^c, c, 1'b0};
`else
      return {1'b1, stopBit, c, 1'b0};
`endif
   endfunction

   task automatic sendBits(input logic [10:0] bits);
      for (int i = 0; i < NBITS; i++) begin
         @(negedge uart_clk);
         rxd = bits[i];
         repeat (BIT - 1) @(negedge uart_clk);
      end
   endtask

   task automatic idleBits(input int n);
      @(negedge uart_clk);
      rxd = 1'b1;
      repeat (n * BIT - 1) @(negedge uart_clk);
   endtask

   task automatic sendChar(input logic [7:0] c);
      sendBits(frameBits(c, 1'b1));
      modelByte(c);
   endtask

   task automatic applyStimulus(input string s);
      for (int i = 0; i < s.len(); i++)
         sendChar(s[i]);
   endtask

   task automatic ackPulse();
      @(negedge uart_clk);
      seed_ack = 1'b1;
      @(negedge uart_clk);
      seed_ack = 1'b0;
      mSeedValid = 1'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".seed_word"},  seed_word,          mSeedWord);
      checkOutput({tag, ".seed_valid"}, 32'(seed_valid),    32'(mSeedValid));
      checkOutput({tag, ".overrun"},    32'(overrun),       32'(mOverrun));
      checkOutput({tag, ".rx_byte"},    32'(rx_byte),       32'(mRxByte));
      checkOutput({tag, ".nValid"},     32'(nValid),        32'(eValid));
      checkOutput({tag, ".nFrame"},     32'(nFrame),        32'(eFrame));
      checkOutput({tag, ".nParse"},     32'(nParse),        32'(eParse));
   endtask

   initial begin
      repeat (5) @(negedge uart_clk);
      checkAll("reset");
      reset1 = 1'b1;
      idleBits(2);

      applyStimulus("1A2b3C4d ");
      checkAll("line1");
      checkOutput("line1.const", seed_word, 32'h1A2B3C4D);
      ackPulse();
      checkOutput("ack1", 32'(seed_valid), 32'd0);

      applyStimulus("DEADBEEF\r\n");
      applyStimulus("00000001 ");
      checkAll("overrun");
      checkOutput("overrun.const", seed_word, 32'hDEADBEEF);
      checkOutput("overrun.flag", 32'(overrun), 32'd1);
      ackPulse();
      checkOutput("ack2", 32'(seed_valid), 32'd0);

      applyStimulus("12G45678 ");
      checkAll("badG");
      applyStimulus("1234567 ");
      checkAll("short");
      applyStimulus("123456789 ");
      checkAll("long");

      applyStimulus("1234");
      sendBits(frameBits(8'h41, 1'b0));
      modelFrameErr();
      idleBits(1);
      checkAll("frameErr");
      applyStimulus("5678 ");
      checkAll("afterFrameErr");

      @(negedge uart_clk);
      rxd = 1'b0;
      repeat (6) @(negedge uart_clk);
      idleBits(3);
      checkAll("glitch");

`ifdef RX_PARITY_EN
      sendBits({1'b1, ~(^8'h31), 8'h31, 1'b0});
      modelFrameErr();
      idleBits(1);
      checkAll("badParity");
      sendChar(8'h31);
      checkAll("goodParity");
      sendChar(8'h20);
`endif

      for (int k = 0; k < 4; k++) begin
         logic [31:0] w;
         logic [3:0]  n;
         logic [7:0]  c;
         int          badPos;
         w = $urandom();
         badPos = ($urandom_range(2, 0) == 0) ? int'($urandom_range(7, 0)) : -1;
         if ($urandom_range(1, 0) == 1) ackPulse();
         for (int i = 7; i >= 0; i--) begin
            n = w[i*4 +: 4];
            if (n < 4'd10) c = 8'h30 + {4'h0, n};
            else c = (($urandom_range(1, 0) == 1) ? 8'h61 : 8'h41) + {4'h0, n} - 8'd10;
            if (i == badPos) c = 8'h7A;
            sendChar(c);
         end
         case ($urandom_range(2, 0))
            0: sendChar(8'h20);
            1: sendChar(8'h0D);
            default: sendChar(8'h0A);
         endcase
         checkAll($sformatf("rand%0d", k));
      end

      applyStimulus("ABCD");
      @(negedge uart_clk);
      rxd = 1'b0;
      repeat (BIT + BIT / 2) @(negedge uart_clk);
      reset1 = 1'b0;
      modelReset();
      repeat (4) @(negedge uart_clk);
      checkAll("midReset");
      reset1 = 1'b1;
      repeat (3 * BIT) @(negedge uart_clk);
      idleBits(12);
      checkAll("rearm");
      applyStimulus("CAFEF00D ");
      checkAll("cafe");
      checkOutput("cafe.const", seed_word, 32'hCAFEF00D);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
